spi_byte_receiver: RTL

//  SPI-slave front end that sits directly upstream of the TPU top.

---
 rtl/tpu_spi_pkg.sv | 15 +
 rtl/spi_rx_fifo.sv | 53 +++++
 rtl/spi_byte_receiver.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/tpu_spi_pkg.sv
// rtl/tpu_spi_pkg.sv - shared SPI receiver types and TPU stream header bytes
package tpu_spi_pkg;

    typedef enum logic [1:0] {
        RESYNC,
        IDLE,
        RECV
    } spi_rx_state_e;

    localparam int SPI_DATA_WIDTH = 8;

    localparam logic [7:0] GRID_HEADER = 8'hD5;
    localparam logic [7:0] MOVE_HEADER = 8'hEA;

endpackage

// File: rtl/spi_rx_fifo.sv
// rtl/spi_rx_fifo.sv - synchronous show-ahead byte FIFO with registered storage
module spi_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [DATA_WIDTH-1:0] last_head;
    logic                  push_ok;
    logic                  pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Once drained, the head keeps showing the last byte handed downstream.
    assign head = empty ? last_head : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            last_head <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                last_head <= mem[rd_ptr[AW-1:0]];
                rd_ptr    <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_byte_receiver.sv
// rtl/spi_byte_receiver.sv - mode-0 SPI slave byte deserialiser feeding the TPU byte stream; SPI_RX_FIFO_EN selects FIFO vs single holding register
module spi_byte_receiver
    import tpu_spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_sclk,
    input  logic                  spi_mosi,
    input  logic                  spi_cs_n,
    input  logic                  out_ready,
    output logic                  spi_ov,
    output logic [DATA_WIDTH-1:0] spi_od,
    output logic                  frame_active,
    output logic                  overflow,
    output logic                  frame_err,
    input  logic                  clr_status
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync, settle_sr;
    logic                   sclk_d, cs_n_d;
    logic                   sclk_s, mosi_s, cs_n_s, settled;
    logic                   sclk_rise, cs_rise, cs_fall;

    spi_rx_state_e          state, state_next;
    logic [DATA_WIDTH-2:0]  shift, shift_next;
    logic [CW-1:0]          bit_cnt, cnt_next;
    logic                   push, set_frame_err, set_overflow, pop, buf_full;
    logic [DATA_WIDTH-1:0]  push_data;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_n_s    = cs_sync[SYNC_STAGES-1];
    // The synchroniser resets to "deselected"; only trust cs_n once that reset value has flushed out.
    assign settled   = settle_sr[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign cs_rise   = cs_n_s & ~cs_n_d;
    assign cs_fall   = ~cs_n_s & cs_n_d;
    assign push_data = {shift, mosi_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            settle_sr <= '0;
            sclk_d    <= 1'b0;
            cs_n_d    <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            settle_sr <= {settle_sr[SYNC_STAGES-2:0], 1'b1};
            sclk_d    <= sclk_s;
            cs_n_d    <= cs_n_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RESYNC;
            shift   <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_next;
            shift   <= shift_next;
            bit_cnt <= cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        shift_next    = shift;
        cnt_next      = bit_cnt;
        push          = 1'b0;
        set_frame_err = 1'b0;
        case (state)
            RESYNC: begin
                if (settled && cs_n_s) state_next = IDLE;
            end
            IDLE: begin
                if (cs_fall) begin
                    state_next = RECV;
                    cnt_next   = '0;
                end
            end
            RECV: begin
                // Deselect beats a coincident sclk rise: that bit is dropped.
                if (cs_rise) begin
                    state_next    = IDLE;
                    cnt_next      = '0;
                    set_frame_err = (bit_cnt != '0);
                end else if (sclk_rise) begin
                    shift_next = {shift[DATA_WIDTH-3:0], mosi_s};
                    if (bit_cnt == LAST_BIT) begin
                        push     = 1'b1;
                        cnt_next = '0;
                    end else begin
                        cnt_next = bit_cnt + CW'(1);
                    end
                end
            end
            default: state_next = RESYNC;
        endcase
    end

    assign frame_active = (state == RECV);
    assign pop          = spi_ov & out_ready;
    assign set_overflow = push & buf_full & ~pop;

`ifdef SPI_RX_FIFO_EN
    logic fifo_empty;

    spi_rx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .full      (buf_full),
        .empty     (fifo_empty),
        .head      (spi_od)
    );

    assign spi_ov = ~fifo_empty;
`else
    logic                  hold_valid;
    logic [DATA_WIDTH-1:0] hold_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (push && (!hold_valid || pop)) begin
            hold_valid <= 1'b1;
            hold_data  <= push_data;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end

    assign buf_full = hold_valid;
    assign spi_ov   = hold_valid;
    assign spi_od   = hold_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (set_overflow)    overflow <= 1'b1;
            else if (clr_status) overflow <= 1'b0;
            if (set_frame_err)   frame_err <= 1'b1;
            else if (clr_status) frame_err <= 1'b0;
        end
    end

endmodule
